// File: rtl/l0_cache_fill_unit.sv
// -----------------------------------------------------------------------------
// l0_cache_fill_unit
//
// Write-side controller for the L0 data cache. Owns the cache RAM write port
// (tag, data, per-byte valid bits). After reset it walks every entry and clears
// its valid bits. It installs full words returned for load misses. It merges
// write-through stores into resident lines.
//
// Optional feature macro: L0_CACHE_STORE_ALLOCATE_EN
//   defined   : a store whose tag misses overwrites the entry (tag, lanes,
//               valid = byte_en)
//   undefined : a store whose tag misses leaves the entry untouched
//
// Ports
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_store_*           retiring store (address, lane-aligned data, byte enables)
//   i_rd_tag            RAM tag read at the store index this cycle
//   i_rd_valid_bits     RAM valid bits read at the store index this cycle
//   i_miss_valid/_addr  cacheable load miss; a memory read has been issued
//   i_mem_rsp_*         memory read data returned for the outstanding miss
//   o_wr_*              RAM write port (combinational, lands at the next edge)
//   o_init_done         cache contents are usable
//   o_fill_busy         a miss fill is outstanding
// -----------------------------------------------------------------------------
module l0_cache_fill_unit #(
   parameter int unsigned XLEN                = 32,
   parameter int unsigned CacheDepth          = 128,
   parameter int unsigned CacheTagWidth       = 7,
   parameter int unsigned MEM_BYTE_ADDR_WIDTH = 16,
   parameter logic [XLEN-1:0] MMIO_ADDR       = 32'h4000_0000,
   localparam int unsigned IdxW               = $clog2(CacheDepth)
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_store_valid,
   input  logic [XLEN-1:0]          i_store_address,
   input  logic [XLEN-1:0]          i_store_data,
   input  logic [3:0]               i_store_byte_en,
   input  logic [CacheTagWidth-1:0] i_rd_tag,
   input  logic [3:0]               i_rd_valid_bits,
   input  logic                     i_miss_valid,
   input  logic [XLEN-1:0]          i_miss_address,
   input  logic                     i_mem_rsp_valid,
   input  logic [XLEN-1:0]          i_mem_rsp_data,
   output logic                     o_wr_en,
   output logic [IdxW-1:0]          o_wr_index,
   output logic [CacheTagWidth-1:0] o_wr_tag,
   output logic [XLEN-1:0]          o_wr_data,
   output logic [3:0]               o_wr_byte_en,
   output logic [3:0]               o_wr_valid_bits,
   output logic                     o_init_done,
   output logic                     o_fill_busy
);

   localparam logic [IdxW-1:0] LastIdx = IdxW'(CacheDepth - 1);

   typedef enum logic [1:0] {
      StInit,
      StIdle,
      StWaitRsp,
      StFillPend
   } state_e;

   // --------------------------------------------------------------------------
   // Registered state
   // --------------------------------------------------------------------------
   state_e                   r_state;
   logic [IdxW-1:0]          r_init_cnt;
   logic                     r_cancel;
   logic                     r_init_done;
   logic                     r_fill_busy;
   logic [IdxW-1:0]          r_fill_index;
   logic [CacheTagWidth-1:0] r_fill_tag;
   logic [XLEN-1:0]          r_fill_data;

   // --------------------------------------------------------------------------
   // Address decode
   // --------------------------------------------------------------------------
   function automatic logic f_cacheable(input logic [XLEN-1:0] addr);
      return (addr < MMIO_ADDR) && (addr[XLEN-1:MEM_BYTE_ADDR_WIDTH] == '0);
   endfunction

   logic [IdxW-1:0]          w_store_index;
   logic [CacheTagWidth-1:0] w_store_tag;
   logic                     w_store_cacheable;
   logic [IdxW-1:0]          w_miss_index;
   logic [CacheTagWidth-1:0] w_miss_tag;
   logic                     w_miss_cacheable;

   assign w_store_index     = i_store_address[IdxW+1:2];
   assign w_store_tag       = i_store_address[MEM_BYTE_ADDR_WIDTH-1:IdxW+2];
   assign w_store_cacheable = f_cacheable(i_store_address);
   assign w_miss_index      = i_miss_address[IdxW+1:2];
   assign w_miss_tag        = i_miss_address[MEM_BYTE_ADDR_WIDTH-1:IdxW+2];
   assign w_miss_cacheable  = f_cacheable(i_miss_address);

   // Byte offset within the word does not take part in indexing.
   logic w_unused_addr_bits;
   assign w_unused_addr_bits = ^{i_store_address[1:0], i_miss_address[1:0]};

   // --------------------------------------------------------------------------
   // Store path
   // --------------------------------------------------------------------------
   logic w_active;
   logic w_store_take;
   logic w_store_hit;
   logic w_store_write;

   assign w_active     = (r_state != StInit);
   assign w_store_take = w_active && i_store_valid && w_store_cacheable;
   assign w_store_hit  = (i_rd_tag == w_store_tag);

`ifdef L0_CACHE_STORE_ALLOCATE_EN
   assign w_store_write = w_store_take;
`else
   assign w_store_write = w_store_take && w_store_hit;
`endif

   // --------------------------------------------------------------------------
   // Fill path
   // --------------------------------------------------------------------------
   logic            w_fill_open;
   logic            w_store_match;
   logic            w_cancel;
   logic            w_fill_ready;
   logic            w_fill_write;
   logic [XLEN-1:0] w_fill_data;

   assign w_fill_open = (r_state == StWaitRsp) || (r_state == StFillPend);

   // A store to the very word being fetched makes the returned data stale,
   // whether or not the store itself hits the RAM; the fill must be dropped.
   assign w_store_match = w_fill_open && w_store_take &&
                          (w_store_index == r_fill_index) &&
                          (w_store_tag == r_fill_tag);
   assign w_cancel      = r_cancel || w_store_match;

   assign w_fill_ready = ((r_state == StWaitRsp) && i_mem_rsp_valid) ||
                         (r_state == StFillPend);
   assign w_fill_write = w_fill_ready && !w_cancel && !w_store_write;
   assign w_fill_data  = (r_state == StFillPend) ? r_fill_data : i_mem_rsp_data;

   // --------------------------------------------------------------------------
   // Write port mux: init sweep, then store, then fill
   // --------------------------------------------------------------------------
   always_comb begin
      o_wr_en         = 1'b0;
      o_wr_index      = '0;
      o_wr_tag        = '0;
      o_wr_data       = '0;
      o_wr_byte_en    = 4'h0;
      o_wr_valid_bits = 4'h0;
      if (r_state == StInit) begin
         o_wr_en    = 1'b1;
         o_wr_index = r_init_cnt;
      end else if (w_store_write) begin
         o_wr_en      = 1'b1;
         o_wr_index   = w_store_index;
         o_wr_tag     = w_store_tag;
         o_wr_data    = i_store_data;
         o_wr_byte_en = i_store_byte_en;
         // Tag hit merges into resident lanes; an allocating miss starts fresh.
         o_wr_valid_bits = w_store_hit ? (i_rd_valid_bits | i_store_byte_en)
                                       : i_store_byte_en;
      end else if (w_fill_write) begin
         o_wr_en         = 1'b1;
         o_wr_index      = r_fill_index;
         o_wr_tag        = r_fill_tag;
         o_wr_data       = w_fill_data;
         o_wr_byte_en    = 4'hF;
         o_wr_valid_bits = 4'hF;
      end
   end

   // --------------------------------------------------------------------------
   // Control FSM
   // --------------------------------------------------------------------------
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state      <= StInit;
         r_init_cnt   <= '0;
         r_cancel     <= 1'b0;
         r_init_done  <= 1'b0;
         r_fill_busy  <= 1'b0;
         r_fill_index <= '0;
         r_fill_tag   <= '0;
         r_fill_data  <= '0;
      end else begin
         unique case (r_state)
            StInit: begin
               r_init_cnt <= r_init_cnt + 1'b1;
               if (r_init_cnt == LastIdx) begin
                  r_state     <= StIdle;
                  r_init_done <= 1'b1;
               end
            end
            StIdle: begin
               if (i_miss_valid && w_miss_cacheable) begin
                  r_fill_index <= w_miss_index;
                  r_fill_tag   <= w_miss_tag;
                  r_cancel     <= 1'b0;
                  r_fill_busy  <= 1'b1;
                  r_state      <= StWaitRsp;
               end
            end
            StWaitRsp: begin
               if (i_mem_rsp_valid) begin
                  if (w_cancel || !w_store_write) begin
                     // Written this cycle, or consumed without a write.
                     r_cancel    <= 1'b0;
                     r_fill_busy <= 1'b0;
                     r_state     <= StIdle;
                  end else begin
                     // Port taken by a store: park the data for a later cycle.
                     r_fill_data <= i_mem_rsp_data;
                     r_state     <= StFillPend;
                  end
               end else if (w_store_match) begin
                  r_cancel <= 1'b1;
               end
            end
            StFillPend: begin
               if (w_cancel || !w_store_write) begin
                  r_cancel    <= 1'b0;
                  r_fill_busy <= 1'b0;
                  r_state     <= StIdle;
               end
            end
            default: begin
               r_state <= StInit;
            end
         endcase
      end
   end

   assign o_init_done = r_init_done;
   assign o_fill_busy = r_fill_busy;

endmodule

// File: tb/tb_l0_cache_fill_unit.sv
// -----------------------------------------------------------------------------
// tb_l0_cache_fill_unit
//
// Self-checking bench for l0_cache_fill_unit: a table of single-cycle store
// vectors, hand-written multi-cycle sequences (init sweep, fill, cancel,
// blocking stores, reset mid-fill / mid-init) and a randomized run checked
// against a transaction-level model of the cache and the outstanding miss.
// -----------------------------------------------------------------------------
module tb_l0_cache_fill_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        store_valid;
   logic [31:0] store_address;
   logic [31:0] store_data;
   logic [3:0]  store_byte_en;
   logic [6:0]  rd_tag;
   logic [3:0]  rd_valid_bits;
   logic        miss_valid;
   logic [31:0] miss_address;
   logic        mem_rsp_valid;
   logic [31:0] mem_rsp_data;
   logic        wr_en;
   logic [6:0]  wr_index;
   logic [6:0]  wr_tag;
   logic [31:0] wr_data;
   logic [3:0]  wr_byte_en;
   logic [3:0]  wr_valid_bits;
   logic        init_done;
   logic        fill_busy;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   l0_cache_fill_unit dut (
      .i_clk           (clk),
      .i_rst           (rst),
      .i_store_valid   (store_valid),
      .i_store_address (store_address),
      .i_store_data    (store_data),
      .i_store_byte_en (store_byte_en),
      .i_rd_tag        (rd_tag),
      .i_rd_valid_bits (rd_valid_bits),
      .i_miss_valid    (miss_valid),
      .i_miss_address  (miss_address),
      .i_mem_rsp_valid (mem_rsp_valid),
      .i_mem_rsp_data  (mem_rsp_data),
      .o_wr_en         (wr_en),
      .o_wr_index      (wr_index),
      .o_wr_tag        (wr_tag),
      .o_wr_data       (wr_data),
      .o_wr_byte_en    (wr_byte_en),
      .o_wr_valid_bits (wr_valid_bits),
      .o_init_done     (init_done),
      .o_fill_busy     (fill_busy)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Called at a falling edge; drives inputs and lets the outputs settle.
   task automatic set_in(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                         input logic [3:0] sbe, input logic [6:0] rt, input logic [3:0] rvb,
                         input logic mv, input logic [31:0] ma,
                         input logic rv, input logic [31:0] rd);
      store_valid   = sv;
      store_address = sa;
      store_data    = sd;
      store_byte_en = sbe;
      rd_tag        = rt;
      rd_valid_bits = rvb;
      miss_valid    = mv;
      miss_address  = ma;
      mem_rsp_valid = rv;
      mem_rsp_data  = rd;
      #1;
   endtask

   task automatic idle();
      set_in(1'b0, 32'h0, 32'h0, 4'h0, 7'h0, 4'h0, 1'b0, 32'h0, 1'b0, 32'h0);
   endtask

   task automatic adv();
      @(negedge clk);
   endtask

   // Leaves the bench at the falling edge of the first INIT cycle.
   task automatic do_reset();
      rst = 1'b1;
      idle();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic chk_write(input string nm, input logic [6:0] idx, input logic [6:0] tag,
                            input logic [31:0] data, input logic [3:0] be,
                            input logic [3:0] vb);
      chk({nm, "_en"}, 32'(wr_en), 32'd1);
      chk({nm, "_idx"}, 32'(wr_index), 32'(idx));
      chk({nm, "_tag"}, 32'(wr_tag), 32'(tag));
      chk({nm, "_data"}, wr_data, data);
      chk({nm, "_be"}, 32'(wr_byte_en), 32'(be));
      chk({nm, "_vb"}, 32'(wr_valid_bits), 32'(vb));
   endtask

   typedef struct {
      logic        sv;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  be;
      logic [6:0]  rtag;
      logic [3:0]  rvb;
      logic        en;
      logic [6:0]  idx;
      logic [6:0]  tag;
      logic [3:0]  ebe;
      logic [3:0]  evb;
   } vec_t;

   vec_t vecs[8];

   // Reference model state for the randomized run.
   logic [6:0]  m_tag [128];
   logic [3:0]  m_vb  [128];
   int          since_rst;
   bit          pend;
   bit          pend_data;
   bit          pend_kill;
   logic [6:0]  p_idx;
   logic [6:0]  p_tag;
   logic [31:0] p_data;

   function automatic logic [31:0] rnd_addr();
      logic [6:0]  ix;
      logic [6:0]  tg;
      logic [31:0] a;
      int          k;
      k = $urandom_range(0, 9);
      case ($urandom_range(0, 3))
         0:       ix = 7'h01;
         1:       ix = 7'h02;
         2:       ix = 7'h40;
         default: ix = 7'h41;
      endcase
      tg = 7'($urandom_range(0, 2));
      a  = {16'h0, tg, ix, 2'($urandom_range(0, 3))};
      if (k == 0) a = a | 32'h4000_0000;
      if (k == 1) a = a | 32'h0001_0000;
      return a;
   endfunction

   function automatic bit cacheable(input logic [31:0] a);
      return (a < 32'h4000_0000) && (a[31:16] == 16'h0);
   endfunction

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin : main
      // ---------------- vector table ----------------
      vecs[0] = '{1'b1, 32'h0000_0104, 32'h1122_3344, 4'b0011, 7'h00, 4'b1100,
                  1'b1, 7'h41, 7'h00, 4'b0011, 4'b1111};
      vecs[1] = '{1'b1, 32'h4000_0000, 32'hFFFF_FFFF, 4'hF, 7'h00, 4'h0,
                  1'b0, 7'h00, 7'h00, 4'h0, 4'h0};
`ifdef L0_CACHE_STORE_ALLOCATE_EN
      vecs[2] = '{1'b1, 32'h0000_8004, 32'h0000_00A5, 4'b0001, 7'h00, 4'b1110,
                  1'b1, 7'h01, 7'h40, 4'b0001, 4'b0001};
      vecs[7] = '{1'b1, 32'h0000_0204, 32'h5A5A_0000, 4'b1100, 7'h03, 4'b0011,
                  1'b1, 7'h01, 7'h01, 4'b1100, 4'b1100};
`else
      vecs[2] = '{1'b1, 32'h0000_8004, 32'h0000_00A5, 4'b0001, 7'h00, 4'b1110,
                  1'b0, 7'h00, 7'h00, 4'h0, 4'h0};
      vecs[7] = '{1'b1, 32'h0000_0204, 32'h5A5A_0000, 4'b1100, 7'h03, 4'b0011,
                  1'b0, 7'h00, 7'h00, 4'h0, 4'h0};
`endif
      vecs[3] = '{1'b0, 32'h0000_0104, 32'h0BAD_0BAD, 4'hF, 7'h00, 4'h0,
                  1'b0, 7'h00, 7'h00, 4'h0, 4'h0};
      vecs[4] = '{1'b1, 32'h0001_0000, 32'h0BAD_0BAD, 4'hF, 7'h00, 4'h0,
                  1'b0, 7'h00, 7'h00, 4'h0, 4'h0};
      vecs[5] = '{1'b1, 32'h0000_FFFC, 32'h8800_0000, 4'b1000, 7'h7F, 4'b0001,
                  1'b1, 7'h7F, 7'h7F, 4'b1000, 4'b1001};
      vecs[6] = '{1'b1, 32'h0000_0300, 32'h0077_6600, 4'b0110, 7'h01, 4'b0000,
                  1'b1, 7'h40, 7'h01, 4'b0110, 4'b0110};

      // ---------------- reset and init sweep ----------------
      do_reset();
      for (int i = 0; i < 128; i++) begin
         // Stores and misses during INIT must be ignored.
         set_in(1'b1, 32'h0000_0104, 32'hFFFF_FFFF, 4'hF, 7'h00, 4'h0,
                1'b1, 32'h0000_0104, 1'b1, 32'h1234_5678);
         chk("init_en", 32'(wr_en), 32'd1);
         chk("init_idx", 32'(wr_index), 32'(i));
         chk("init_be", 32'(wr_byte_en), 32'd0);
         chk("init_vb", 32'(wr_valid_bits), 32'd0);
         chk("init_done_low", 32'(init_done), 32'd0);
         chk("init_busy", 32'(fill_busy), 32'd0);
         adv();
      end
      idle();
      chk("init_done_high", 32'(init_done), 32'd1);
      chk("post_init_en", 32'(wr_en), 32'd0);
      chk("post_init_busy", 32'(fill_busy), 32'd0);
      adv();

      // ---------------- store vector table ----------------
      foreach (vecs[v]) begin
         set_in(vecs[v].sv, vecs[v].addr, vecs[v].data, vecs[v].be, vecs[v].rtag,
                vecs[v].rvb, 1'b0, 32'h0, 1'b0, 32'h0);
         chk($sformatf("vec%0d_en", v), 32'(wr_en), 32'(vecs[v].en));
         if (vecs[v].en) begin
            chk($sformatf("vec%0d_idx", v), 32'(wr_index), 32'(vecs[v].idx));
            chk($sformatf("vec%0d_tag", v), 32'(wr_tag), 32'(vecs[v].tag));
            chk($sformatf("vec%0d_data", v), wr_data, vecs[v].data);
            chk($sformatf("vec%0d_be", v), 32'(wr_byte_en), 32'(vecs[v].ebe));
            chk($sformatf("vec%0d_vb", v), 32'(wr_valid_bits), 32'(vecs[v].evb));
         end
         adv();
      end

      // ---------------- basic fill ----------------
      set_in(1'b0, 32'h0, 32'h0, 4'h0, 7'h0, 4'h0, 1'b1, 32'h0000_0104, 1'b0, 32'h0);
      chk("fill_busy_t0", 32'(fill_busy), 32'd0);
      adv();
      idle();
      chk("fill_busy_t1", 32'(fill_busy), 32'd1);
      chk("fill_nowr_t1", 32'(wr_en), 32'd0);
      adv();
      set_in(1'b0, 32'h0, 32'h0, 4'h0, 7'h0, 4'h0, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF);
      chk_write("fill", 7'h41, 7'h00, 32'hDEAD_BEEF, 4'hF, 4'hF);
      adv();
      idle();
      chk("fill_busy_done", 32'(fill_busy), 32'd0);
      adv();

      // ---------------- uncacheable miss ignored ----------------
      set_in(1'b0, 32'h0, 32'h0, 4'h0, 7'h0, 4'h0, 1'b1, 32'h4000_0104, 1'b0, 32'h0);
      adv();
      set_in(1'b0, 32'h0, 32'h0, 4'h0, 7'h0, 4'h0, 1'b0, 32'h0, 1'b1, 32'h1111_1111);
      chk("mmio_miss_busy", 32'(fill_busy), 32'd0);
      chk("mmio_miss_nowr", 32'(wr_en), 32'd0);
      adv();

      // ---------------- cancel by store to same word ----------------
      set_in(1'b0, 32'h0, 32'h0, 4'h0, 7'h0, 4'h0, 1'b1, 32'h0000_0208, 1'b0, 32'h0);
      adv();
      set_in(1'b1, 32'h0000_0208, 32'h0000_CAFE, 4'b0011, 7'h01, 4'h0, 1'b0, 32'h0, 1'b0, 32'h0);
      chk_write("cancel_st", 7'h02, 7'h01, 32'h0000_CAFE, 4'b0011, 4'b0011);
      adv();
      set_in(1'b0, 32'h0, 32'h0, 4'h0, 7'h0, 4'h0, 1'b0, 32'h0, 1'b1, 32'h1234_5678);
      chk("cancel_rsp_nowr", 32'(wr_en), 32'd0);
      adv();
      idle();
      chk("cancel_busy_drop", 32'(fill_busy), 32'd0);
      adv();

      // ---------------- same index, other tag: no cancel ----------------
      set_in(1'b0, 32'h0, 32'h0, 4'h0, 7'h0, 4'h0, 1'b1, 32'h0000_0208, 1'b0, 32'h0);
      adv();
      set_in(1'b1, 32'h0000_0408, 32'h0000_0408, 4'hF, 7'h02, 4'h0, 1'b0, 32'h0, 1'b0, 32'h0);
      adv();
      set_in(1'b0, 32'h0, 32'h0, 4'h0, 7'h0, 4'h0, 1'b0, 32'h0, 1'b1, 32'h0BEE_0BEE);
      chk_write("nocancel", 7'h02, 7'h01, 32'h0BEE_0BEE, 4'hF, 4'hF);
      adv();

      // ---------------- response blocked by one store, then two ----------------
      for (int nblk = 1; nblk <= 2; nblk++) begin
         set_in(1'b0, 32'h0, 32'h0, 4'h0, 7'h0, 4'h0, 1'b1, 32'h0000_0104, 1'b0, 32'h0);
         adv();
         set_in(1'b1, 32'h0000_0300, 32'h0300_0300, 4'hF, 7'h01, 4'hF,
                1'b0, 32'h0, 1'b1, 32'hAAAA_5555);
         chk_write("blk_st0", 7'h40, 7'h01, 32'h0300_0300, 4'hF, 4'hF);
         adv();
         if (nblk == 2) begin
            set_in(1'b1, 32'h0000_0300, 32'h0300_0301, 4'h1, 7'h01, 4'hF,
                   1'b0, 32'h0, 1'b0, 32'h0);
            chk_write("blk_st1", 7'h40, 7'h01, 32'h0300_0301, 4'h1, 4'hF);
            adv();
         end
         idle();
         chk_write("blk_fill", 7'h41, 7'h00, 32'hAAAA_5555, 4'hF, 4'hF);
         chk("blk_busy", 32'(fill_busy), 32'd1);
         adv();
         idle();
         chk("blk_busy_done", 32'(fill_busy), 32'd0);
         chk("blk_nowr", 32'(wr_en), 32'd0);
         adv();
      end

      // ---------------- reset mid-fill and mid-init ----------------
      set_in(1'b0, 32'h0, 32'h0, 4'h0, 7'h0, 4'h0, 1'b1, 32'h0000_0104, 1'b0, 32'h0);
      adv();
      do_reset();
      set_in(1'b0, 32'h0, 32'h0, 4'h0, 7'h0, 4'h0, 1'b0, 32'h0, 1'b1, 32'h0000_0001);
      chk("rst_fill_idx0", 32'(wr_index), 32'd0);
      chk("rst_fill_vb", 32'(wr_valid_bits), 32'd0);
      chk("rst_fill_busy", 32'(fill_busy), 32'd0);
      adv();
      for (int i = 1; i < 50; i++) begin
         idle();
         adv();
      end
      do_reset();
      idle();
      chk("rst_init_idx0", 32'(wr_index), 32'd0);
      chk("rst_init_done", 32'(init_done), 32'd0);
      adv();
      for (int i = 1; i < 128; i++) begin
         idle();
         adv();
      end
      set_in(1'b0, 32'h0, 32'h0, 4'h0, 7'h0, 4'h0, 1'b0, 32'h0, 1'b1, 32'h0000_0009);
      chk("late_rsp_nowr", 32'(wr_en), 32'd0);
      chk("late_rsp_done", 32'(init_done), 32'd1);
      chk("late_rsp_busy", 32'(fill_busy), 32'd0);
      adv();

      // ---------------- randomized run against the model ----------------
      for (int i = 0; i < 128; i++) begin
         m_tag[i] = 7'($urandom_range(0, 2));
         m_vb[i]  = 4'($urandom);
      end
      do_reset();
      since_rst = 0;
      pend      = 1'b0;
      pend_data = 1'b0;
      pend_kill = 1'b0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         logic        sv, mv, rv, e_en, st_wr, was_pend;
         logic [31:0] sa, sd, ma, rd, e_data;
         logic [3:0]  sbe, e_be, e_vb;
         logic [6:0]  sidx, stag, e_idx, e_tag;
         bit          in_init;
         if ($urandom_range(0, 999) == 0) begin
            do_reset();
            since_rst = 0;
            pend      = 1'b0;
            continue;
         end
         sv   = ($urandom_range(0, 9) < 4);
         sa   = rnd_addr();
         sd   = $urandom;
         sbe  = 4'($urandom_range(1, 15));
         mv   = ($urandom_range(0, 99) < 15);
         ma   = rnd_addr();
         rv   = ($urandom_range(0, 99) < 25);
         rd   = $urandom;
         sidx = sa[8:2];
         stag = sa[15:9];
         set_in(sv, sa, sd, sbe, m_tag[sidx], m_vb[sidx], mv, ma, rv, rd);

         in_init = (since_rst < 128);
         e_en = 1'b0; e_idx = '0; e_tag = '0; e_data = '0; e_be = '0; e_vb = '0;
         st_wr = 1'b0;
         was_pend = pend;
         if (in_init) begin
            e_en  = 1'b1;
            e_idx = 7'(since_rst);
            m_vb[e_idx] = 4'h0;
         end else begin
            if (sv && cacheable(sa)) begin
               if (pend && sidx == p_idx && stag == p_tag) pend_kill = 1'b1;
               if (m_tag[sidx] == stag) begin
                  st_wr = 1'b1;
                  e_vb  = m_vb[sidx] | sbe;
               end
`ifdef L0_CACHE_STORE_ALLOCATE_EN
               else begin
                  st_wr = 1'b1;
                  e_vb  = sbe;
               end
`endif
            end
            if (st_wr) begin
               e_en = 1'b1; e_idx = sidx; e_tag = stag; e_data = sd; e_be = sbe;
            end
            if (pend && !pend_data && rv) begin
               pend_data = 1'b1;
               p_data    = rd;
            end
            if (pend && pend_data) begin
               if (pend_kill) begin
                  pend = 1'b0;
               end else if (!st_wr) begin
                  e_en = 1'b1; e_idx = p_idx; e_tag = p_tag; e_data = p_data;
                  e_be = 4'hF; e_vb = 4'hF;
                  pend = 1'b0;
               end
            end
            if (e_en) begin
               m_tag[e_idx] = e_tag;
               m_vb[e_idx]  = e_vb;
            end
            if (!was_pend && mv && cacheable(ma)) begin
               pend      = 1'b1;
               pend_data = 1'b0;
               pend_kill = 1'b0;
               p_idx     = ma[8:2];
               p_tag     = ma[15:9];
            end
         end

         chk("rnd_en", 32'(wr_en), 32'(e_en));
         chk("rnd_busy", 32'(fill_busy), 32'(was_pend));
         chk("rnd_done", 32'(init_done), 32'(!in_init));
         if (e_en) begin
            chk("rnd_idx", 32'(wr_index), 32'(e_idx));
            chk("rnd_be", 32'(wr_byte_en), 32'(e_be));
            chk("rnd_vb", 32'(wr_valid_bits), 32'(e_vb));
            if (!in_init) begin
               chk("rnd_tag", 32'(wr_tag), 32'(e_tag));
               chk("rnd_data", wr_data, e_data);
            end
         end
         if (since_rst < 200) since_rst++;
         adv();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
